// File: rtl/pixel_shader_pkg.sv
// Shared constants for the pixel shader: shading modes, line FSM states, unity gain.
package pixel_shader_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_GAIN = 2'd2;
  localparam logic [1:0] MODE_THR  = 2'd3;

  typedef enum logic {
    LINE_IDLE = 1'b0,
    IN_LINE   = 1'b1
  } line_state_e;

  localparam int GAIN_UNITY = 16;

endpackage

// File: rtl/pixel_shader_ch.sv
// Combinational per-channel shading function: passthrough, invert,
// saturating gain/offset (gain is unsigned with 4 fraction bits), threshold.
module pixel_shader_ch
  import pixel_shader_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int GAIN_W = 8
) (
  input  logic [PIX_W-1:0]  pix_i,
  input  logic [1:0]        mode_i,
  input  logic [GAIN_W-1:0] gain_i,
  input  logic [PIX_W:0]    off_i,
  output logic [PIX_W-1:0]  res_o
);

  localparam int TW = PIX_W + GAIN_W + 1;
  localparam logic [PIX_W-1:0] MAX = {PIX_W{1'b1}};

  logic [PIX_W+GAIN_W-1:0] prod_s;
  logic signed [TW-1:0]    t_s;
  logic [PIX_W-1:0]        sat_s;

  // Gain/offset in a signed width wide enough that neither product nor sum can wrap.
  always_comb begin
    prod_s = {{GAIN_W{1'b0}}, pix_i} * {{PIX_W{1'b0}}, gain_i};
    t_s    = $signed({1'b0, prod_s >> 4'd4}) + $signed({{GAIN_W{off_i[PIX_W]}}, off_i});
    if (t_s[TW-1]) begin
      sat_s = {PIX_W{1'b0}};
    end else if (|t_s[TW-2:PIX_W]) begin
      sat_s = MAX;
    end else begin
      sat_s = t_s[PIX_W-1:0];
    end
  end

  always_comb begin
    case (mode_i)
      MODE_PASS: res_o = pix_i;
      MODE_INV:  res_o = MAX - pix_i;
      MODE_GAIN: res_o = sat_s;
      MODE_THR:  res_o = (pix_i >= off_i[PIX_W-1:0]) ? MAX : {PIX_W{1'b0}};
      default:   res_o = pix_i;
    endcase
  end

endmodule

// File: rtl/pixel_shader_core.sv
// Two-stage valid/ready per-pixel shader with line-aligned config shadowing.
// Optional statistics counters are built when PIXEL_SHADER_STATS_EN is defined.
module pixel_shader_core
  import pixel_shader_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int NUM_CH = 3,
  parameter int GAIN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NUM_CH*PIX_W-1:0] s_data,
  input  logic                    s_last,
  input  logic [1:0]              cfg_mode,
  input  logic [GAIN_W-1:0]       cfg_gain,
  input  logic [PIX_W:0]          cfg_offset,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM_CH*PIX_W-1:0] m_data,
  output logic                    m_last
`ifdef PIXEL_SHADER_STATS_EN
  ,
  output logic [31:0]             stat_pix_cnt,
  output logic [15:0]             stat_line_cnt
`endif
);

  localparam int DW = NUM_CH * PIX_W;

  line_state_e       state_q;
  logic [1:0]        sh_mode_q;
  logic [GAIN_W-1:0] sh_gain_q;
  logic [PIX_W:0]    sh_off_q;

  logic [1:0]        cur_mode_s;
  logic [GAIN_W-1:0] cur_gain_s;
  logic [PIX_W:0]    cur_off_s;
  logic              adv_s;
  logic              acc_s;

  logic              v1_q;
  logic [DW-1:0]     d1_q;
  logic              last1_q;
  logic [1:0]        mode1_q;
  logic [GAIN_W-1:0] gain1_q;
  logic [PIX_W:0]    off1_q;

  logic              v2_q;
  logic [DW-1:0]     data2_q;
  logic              last2_q;
  logic [DW-1:0]     res_d;

  // The whole pipeline advances together whenever the output slot is free or draining.
  assign adv_s   = !v2_q || m_ready;
  assign acc_s   = s_valid && adv_s;
  assign s_ready = adv_s;
  assign m_valid = v2_q;
  assign m_data  = data2_q;
  assign m_last  = last2_q;

  // First pixel of a line sees the live config; the rest of the line sees the shadow.
  always_comb begin
    if (state_q == LINE_IDLE) begin
      cur_mode_s = cfg_mode;
      cur_gain_s = cfg_gain;
      cur_off_s  = cfg_offset;
    end else begin
      cur_mode_s = sh_mode_q;
      cur_gain_s = sh_gain_q;
      cur_off_s  = sh_off_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LINE_IDLE;
      sh_mode_q <= MODE_PASS;
      sh_gain_q <= GAIN_W'(GAIN_UNITY);
      sh_off_q  <= {(PIX_W+1){1'b0}};
    end else begin
      case (state_q)
        LINE_IDLE: begin
          sh_mode_q <= cfg_mode;
          sh_gain_q <= cfg_gain;
          sh_off_q  <= cfg_offset;
          if (acc_s && !s_last) begin
            state_q <= IN_LINE;
          end
        end
        IN_LINE: begin
          if (acc_s && s_last) begin
            state_q <= LINE_IDLE;
          end
        end
        default: state_q <= LINE_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pixel_shader_ch #(
      .PIX_W  (PIX_W),
      .GAIN_W (GAIN_W)
    ) u_ch (
      .pix_i  (d1_q[c*PIX_W +: PIX_W]),
      .mode_i (mode1_q),
      .gain_i (gain1_q),
      .off_i  (off1_q),
      .res_o  (res_d[c*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      d1_q    <= {DW{1'b0}};
      last1_q <= 1'b0;
      mode1_q <= MODE_PASS;
      gain1_q <= GAIN_W'(GAIN_UNITY);
      off1_q  <= {(PIX_W+1){1'b0}};
      v2_q    <= 1'b0;
      data2_q <= {DW{1'b0}};
      last2_q <= 1'b0;
    end else if (adv_s) begin
      v1_q    <= s_valid;
      d1_q    <= s_data;
      last1_q <= s_last;
      mode1_q <= cur_mode_s;
      gain1_q <= cur_gain_s;
      off1_q  <= cur_off_s;
      v2_q    <= v1_q;
      data2_q <= res_d;
      last2_q <= last1_q;
    end
  end

`ifdef PIXEL_SHADER_STATS_EN
  logic [31:0] pix_cnt_q;
  logic [15:0] line_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q  <= 32'd0;
      line_cnt_q <= 16'd0;
    end else if (v2_q && m_ready) begin
      pix_cnt_q <= pix_cnt_q + 32'd1;
      if (last2_q) begin
        line_cnt_q <= line_cnt_q + 16'd1;
      end
    end
  end

  assign stat_pix_cnt  = pix_cnt_q;
  assign stat_line_cnt = line_cnt_q;
`endif

endmodule
